// File: rtl/exe_wb_arbiter.sv
// exe_wb_arbiter
//   Registered, fair result arbiter between the function units and the ROB
//   writeback ports. Each cycle it scans nfu x ewd FU response lanes and packs
//   the winners into the free output slots. An output slot is held until the ROB
//   accepts it. Priority rotates, and an FU that has lost too many cycles in a row
//   is escalated ahead of the rotation.
//
//   Every bundle is bw bits wide. The opid field sits in the low 16 bits, and
//   bit vbit (opid[15]) is the valid flag.
//
// Ports
//   clk         clock
//   rst         asynchronous reset, active low (0 = reset)
//   flush       synchronous pipeline flush
//   fu_resp     nfu*ewd response lanes; lane (f,l) is at [(f*ewd+l)*bw +: bw]
//   fu_claim    lane accepted this cycle; bit index f*ewd+l (combinational)
//   out_ready   ROB consumes slot k this cycle
//   exe_bundle  registered output slots; slot k is at [k*bw +: bw]
//   rr_ptr      current top-priority FU of the rotation
module exe_wb_arbiter #(
  parameter int nfu    = 5,
  parameter int ewd    = 2,
  parameter int owd    = 2,
  parameter int starve = 8,
  parameter int bw     = 32,
  parameter int vbit   = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [nfu*ewd*bw-1:0]      fu_resp,
  output logic [nfu*ewd-1:0]         fu_claim,
  input  logic [owd-1:0]             out_ready,
  output logic [owd*bw-1:0]          exe_bundle,
  output logic [$clog2(nfu)-1:0]     rr_ptr
);

  localparam int nl = nfu * ewd;
  localparam int cw = $clog2(owd + 1);
  localparam int sw = $clog2(starve + 1);
  localparam int pw = $clog2(nfu);
  localparam logic [sw-1:0] starve_c  = sw'(starve);
  localparam logic [pw-1:0] ptr_rst_c = pw'(nfu - 1);

  logic [bw-1:0] slot_q [owd];
  logic [bw-1:0] slot_d [owd];
  logic [sw-1:0] cnt_q  [nfu];
  logic [sw-1:0] cnt_d  [nfu];
  logic [pw-1:0] ptr_q;
  logic [pw-1:0] ptr_d;

  logic [cw-1:0]  nfree_s;
  logic [cw-1:0]  nwin_s;
  int             slot_of_s [owd+1];
  logic [nl-1:0]  claim_s;
  logic [nfu-1:0] won_fu_s;
  logic [nfu-1:0] lost_fu_s;
  logic           miss_found_s;

  // Build the ascending list of free slots. A slot is free when it is empty or the ROB drains it now.
  always_comb begin : free_list_p
    nfree_s = '0;
    for (int k = 0; k <= owd; k++) begin
      slot_of_s[k] = 0;
    end
    for (int k = 0; k < owd; k++) begin
      if (!slot_q[k][vbit] || out_ready[k]) begin
        slot_of_s[nfree_s] = k;
        nfree_s = nfree_s + cw'(1);
      end else begin
        nfree_s = nfree_s;
      end
    end
  end

  // Scan the lanes and assign winners to free slots. Scan positions 0..nfu-1 visit the
  // starved FUs in ascending order. Positions nfu..2*nfu-1 walk down from ptr_q over the
  // FUs that are not starved.
  always_comb begin : scan_p
    int  f;
    int  ln;
    logic elig;
    f            = 0;
    ln           = 0;
    elig         = 1'b0;
    nwin_s       = '0;
    claim_s      = '0;
    won_fu_s     = '0;
    lost_fu_s    = '0;
    miss_found_s = 1'b0;
    ptr_d        = ptr_q;
    for (int k = 0; k < owd; k++) begin
      // A held slot keeps its value. A freed slot clears unless a winner refills it below.
      slot_d[k] = (slot_q[k][vbit] && !out_ready[k]) ? slot_q[k] : '0;
    end
    for (int p = 0; p < 2 * nfu; p++) begin
      if (p < nfu) begin
        f    = p;
        elig = (cnt_q[f] == starve_c);
      end else begin
        f = int'(ptr_q) - (p - nfu);
        if (f < 0) begin
          f = f + nfu;
        end else begin
          f = f;
        end
        elig = (cnt_q[f] != starve_c);
      end
      for (int l = 0; l < ewd; l++) begin
        ln = f * ewd + l;
        if (elig && fu_resp[ln*bw + vbit]) begin
          if (nwin_s < nfree_s) begin
            claim_s[ln]                 = 1'b1;
            won_fu_s[f]                 = 1'b1;
            slot_d[slot_of_s[nwin_s]]   = fu_resp[ln*bw +: bw];
            nwin_s                      = nwin_s + cw'(1);
          end else begin
            lost_fu_s[f] = 1'b1;
            // The rotation restarts at the first FU in scan order that was left waiting.
            if (!miss_found_s) begin
              miss_found_s = 1'b1;
              ptr_d        = pw'(f);
            end else begin
              ptr_d = ptr_d;
            end
          end
        end else begin
          nwin_s = nwin_s;
        end
      end
    end
  end

  // Starvation counters: a claim clears the counter and a loss increments it (saturating). With no valid lane the counter holds.
  always_comb begin : cnt_next_p
    for (int f = 0; f < nfu; f++) begin
      cnt_d[f] = cnt_q[f];
      if (won_fu_s[f]) begin
        cnt_d[f] = '0;
      end else if (lost_fu_s[f]) begin
        cnt_d[f] = (cnt_q[f] == starve_c) ? cnt_q[f] : cnt_q[f] + sw'(1);
      end else begin
        cnt_d[f] = cnt_q[f];
      end
    end
  end

  // State registers: asynchronous reset, then flush, then the normal update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < owd; k++) slot_q[k] <= '0;
      for (int f = 0; f < nfu; f++) cnt_q[f] <= '0;
      ptr_q <= ptr_rst_c;
    end else if (flush) begin
      for (int k = 0; k < owd; k++) slot_q[k] <= '0;
      for (int f = 0; f < nfu; f++) cnt_q[f] <= '0;
      ptr_q <= ptr_rst_c;
    end else begin
      for (int k = 0; k < owd; k++) slot_q[k] <= slot_d[k];
      for (int f = 0; f < nfu; f++) cnt_q[f] <= cnt_d[f];
      ptr_q <= ptr_d;
    end
  end

  // Flatten the slot registers onto the output bus.
  always_comb begin : out_pack_p
    exe_bundle = '0;
    for (int k = 0; k < owd; k++) begin
      exe_bundle[k*bw +: bw] = slot_q[k];
    end
  end

  // A claim is never reported during reset or flush, because nothing is written at the next edge.
  assign fu_claim = (rst && !flush) ? claim_s : '0;
  assign rr_ptr   = ptr_q;

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// tb_exe_wb_arbiter
//   Directed bench for exe_wb_arbiter with the default parameters
//   (nfu=5, ewd=2, owd=2, starve=8, bw=32). The expected values are worked out by hand.
module tb_exe_wb_arbiter;

  localparam int nfu = 5;
  localparam int ewd = 2;
  localparam int owd = 2;
  localparam int bw  = 32;
  localparam int nl  = nfu * ewd;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [nl*bw-1:0]  fu_resp;
  logic [nl-1:0]     fu_claim;
  logic [owd-1:0]    out_ready;
  logic [owd*bw-1:0] exe_bundle;
  logic [2:0]        rr_ptr;

  int n_assert = 0;
  int n_fail   = 0;

  exe_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .fu_resp    (fu_resp),
    .fu_claim   (fu_claim),
    .out_ready  (out_ready),
    .exe_bundle (exe_bundle),
    .rr_ptr     (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // The payload of lane (f,l) is unique per lane, and bit 15 carries the valid flag.
  function automatic logic [31:0] mk(input int f, input int l);
    return {8'(f), 8'(l), 16'h8000 | 16'(f * 16 + l)};
  endfunction

  // Present the lanes in mask as valid. The other lanes carry data with the valid bit cleared.
  function automatic logic [nl*bw-1:0] lanes(input logic [nl-1:0] m);
    logic [nl*bw-1:0] r;
    r = '0;
    for (int ln = 0; ln < nl; ln++) begin
      r[ln*bw +: bw] = m[ln] ? mk(ln / ewd, ln % ewd) : (mk(ln / ewd, ln % ewd) & 32'hFFFF_7FFF);
    end
    return r;
  endfunction

  task automatic drive(input logic [nl-1:0] m, input logic [owd-1:0] r, input logic fl);
    fu_resp   = lanes(m);
    out_ready = r;
    flush     = fl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [nl-1:0] e_claim;
    int            f;
    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = '0;
    fu_resp   = lanes(10'h3FF);
    repeat (2) @(posedge clk);
    #3;
    check_eq("reset_bundle", exe_bundle, 64'h0);
    check_eq("reset_rr", rr_ptr, 3'd4);
    check_eq("reset_claim", fu_claim, 10'h000);
    rst = 1'b1;

    // FU4 lane0 and FU0 lane1 are valid and both slots are free.
    drive(10'h102, 2'b00, 1'b0);
    check_eq("t1_claim", fu_claim, 10'h102);
    tick();
    check_eq("t1_bundle", exe_bundle, {mk(0, 1), mk(4, 0)});
    check_eq("t1_rr", rr_ptr, 3'd4);

    // All lanes are valid and both slots drain every cycle, so one whole FU wins per cycle and the pointer rotates.
    for (int i = 0; i < nfu; i++) begin
      f       = 4 - i;
      e_claim = 10'b11;
      e_claim = e_claim << (2 * f);
      drive(10'h3FF, 2'b11, 1'b0);
      check_eq("t2_claim", fu_claim, e_claim);
      tick();
      check_eq("t2_bundle", exe_bundle, {mk(f, 1), mk(f, 0)});
      check_eq("t2_rr", rr_ptr, (f == 0) ? 3'd4 : 3'(f - 1));
    end

    // Flush while the slots are valid and lanes are presented.
    drive(10'h3FF, 2'b11, 1'b1);
    check_eq("flush_claim", fu_claim, 10'h000);
    tick();
    check_eq("flush_bundle", exe_bundle, 64'h0);
    check_eq("flush_rr", rr_ptr, 3'd4);

    // Fill both slots with FU1 data.
    drive(10'h00C, 2'b00, 1'b0);
    check_eq("fill_claim", fu_claim, 10'h00C);
    tick();
    check_eq("fill_bundle", exe_bundle, {mk(1, 1), mk(1, 0)});

    // The slots are full and not drained. FU2 loses 10 cycles in a row.
    for (int i = 0; i < 10; i++) begin
      drive(10'h030, 2'b00, 1'b0);
      check_eq("t3_claim_blocked", fu_claim, 10'h000);
      tick();
      check_eq("t3_rr", rr_ptr, 3'd2);
    end
    check_eq("t3_bundle_held", exe_bundle, {mk(1, 1), mk(1, 0)});
    // Only FU4 is presented, so the pointer moves to 4 and FU2 keeps its counter.
    drive(10'h300, 2'b00, 1'b0);
    check_eq("t3_claim_fu4", fu_claim, 10'h000);
    tick();
    check_eq("t3_rr_fu4", rr_ptr, 3'd4);
    // Slot0 frees. Starved FU2 beats FU4 even though the rotation points at FU4.
    drive(10'h330, 2'b01, 1'b0);
    check_eq("t3_claim_escalate", fu_claim, 10'h010);
    tick();
    check_eq("t3_bundle_escalate", exe_bundle, {mk(1, 1), mk(2, 0)});
    check_eq("t3_rr_escalate", rr_ptr, 3'd2);

    // Slot0 is held and slot1 drains. Three lanes are valid and only FU2 lane1 wins, into slot1.
    drive(10'h061, 2'b10, 1'b0);
    check_eq("t4_claim", fu_claim, 10'h020);
    tick();
    check_eq("t4_bundle", exe_bundle, {mk(2, 1), mk(2, 0)});
    check_eq("t4_rr", rr_ptr, 3'd0);

    // Both slots drain and no lane is valid, so the slots load invalid.
    drive(10'h000, 2'b11, 1'b0);
    check_eq("empty_claim", fu_claim, 10'h000);
    tick();
    check_eq("empty_bundle", exe_bundle, 64'h0);
    check_eq("empty_rr", rr_ptr, 3'd0);

    // Refill the slots, then assert the reset between clock edges.
    drive(10'h00C, 2'b00, 1'b0);
    check_eq("t6_claim", fu_claim, 10'h00C);
    tick();
    check_eq("t6_bundle_pre", exe_bundle, {mk(1, 1), mk(1, 0)});
    rst = 1'b0;
    #1;
    check_eq("t6_bundle_async", exe_bundle, 64'h0);
    check_eq("t6_rr_async", rr_ptr, 3'd4);
    check_eq("t6_claim_async", fu_claim, 10'h000);
    #20;
    rst = 1'b1;
    #10;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
